// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 (poly 0x07, MSB-first) frame checker: strips the trailing CRC byte,
// forwards the payload with a corrected last flag and reports a per-frame status pulse.
module crc8_frame_checker #(
  parameter int         LEN_W    = 16,
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             stat_valid,
  output logic             stat_ok,
  output logic             stat_runt,
  output logic [LEN_W-1:0] stat_len,
  output logic [7:0]       stat_calc
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state, state_next;
  logic [7:0]         hold_data;
  logic [7:0]         crc;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_inc;
  logic               accept;

  // Eight serial MSB-first steps unrolled into one combinational byte update.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  assign len_inc  = (len == '1) ? len : len + LEN_W'(1);
  assign out_data = hold_data;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept && !in_last) state_next = ACTIVE;
      end
      ACTIVE: begin
        // The held byte leaves exactly when the next byte arrives, so both handshakes coincide.
        in_ready  = out_ready;
        out_valid = in_valid;
        out_last  = in_last;
        accept    = in_valid && out_ready;
        if (accept && in_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_data  <= 8'h00;
      crc        <= CRC_INIT;
      len        <= '0;
      stat_valid <= 1'b0;
      stat_ok    <= 1'b0;
      stat_runt  <= 1'b0;
      stat_len   <= '0;
      stat_calc  <= 8'h00;
    end else begin
      state      <= state_next;
      stat_valid <= 1'b0;
      if (accept) begin
        if (state == IDLE) begin
          if (!in_last) begin
            hold_data <= in_data;
            crc       <= crc8_step(CRC_INIT, in_data);
            len       <= LEN_W'(1);
          end else begin
            stat_valid <= 1'b1;
            stat_runt  <= 1'b1;
            stat_ok    <= 1'b0;
            stat_len   <= '0;
            stat_calc  <= CRC_INIT;
          end
        end else if (!in_last) begin
          hold_data <= in_data;
          crc       <= crc8_step(crc, in_data);
          len       <= len_inc;
        end else begin
          // The CRC byte itself is compared, never folded into the checksum.
          stat_valid <= 1'b1;
          stat_runt  <= 1'b0;
          stat_ok    <= (crc == in_data);
          stat_len   <= len;
          stat_calc  <= crc;
          crc        <= CRC_INIT;
          len        <= '0;
        end
      end
    end
  end

endmodule

// File: doc/crc8_frame_checker.md
Name: crc8_frame_checker

Overview:
Receive-side counterpart of the team's 8-bit-parallel CRC-8 generator. Accepts a byte stream framed by a last flag, where the final byte of each frame is the transmitted CRC-8 (poly x^8+x^2+x+1 = 0x07, MSB-first, no reflection, no xorout). It strips the CRC byte, forwards the payload with a corrected last flag, and emits a one-cycle per-frame status pulse with pass/fail, payload length and computed CRC. It sits between the link receiver and the payload consumer.

Parameters:
LEN_W, 16, width of the payload byte counter; the counter saturates at 2^LEN_W-1.
CRC_INIT, 8'h00, CRC register value at the start of each frame; must match the generator.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input byte valid
in_ready  output  1  input byte accepted when in_valid & in_ready
in_data  input  8  received byte
in_last  input  1  marks the CRC byte, which is the last byte of the frame
out_valid  output  1  payload byte valid
out_ready  input  1  downstream ready
out_data  output  8  payload byte
out_last  output  1  last payload byte of the frame
stat_valid  output  1  one-cycle status pulse, no backpressure
stat_ok  output  1  received CRC equals computed CRC, and the frame is not a runt
stat_runt  output  1  frame contained only the CRC byte (zero payload)
stat_len  output  LEN_W  payload byte count, excluding the CRC byte, saturating
stat_calc  output  8  CRC computed over the payload only

Behaviour:
- CRC step: next = f(crc, byte), the same 8-bit parallel matrix as the generator. Single-bit responses are 0x01->0x07, 0x02->0x0E, 0x40->0xC7, 0x80->0x89.
- One-byte holding register (hold_data). A payload byte is forwarded only after the following byte arrives, because only then is it known whether the held byte is the last payload byte.
- FSM states:
  - IDLE: hold register empty.
  - ACTIVE: hold register full.
- IDLE:
  - in_ready=1; out_valid=0.
  - Accept with in_last=0: hold_data<=in_data, crc<=f(CRC_INIT,in_data), len<=1, go to ACTIVE.
  - Accept with in_last=1 (runt): next cycle stat_valid=1, stat_runt=1, stat_ok=0, stat_len=0, stat_calc=CRC_INIT. Stay in IDLE. Nothing is forwarded.
- ACTIVE:
  - in_ready=out_ready; out_valid=in_valid; out_data=hold_data; out_last=in_last. These are combinational pass-through paths.
  - A transfer occurs when in_valid & out_ready. The input and output handshakes complete in the same cycle.
  - Transfer with in_last=0: hold_data<=in_data, crc<=f(crc,in_data), len<=len+1 (saturating). Stay in ACTIVE.
  - Transfer with in_last=1: go to IDLE. Next cycle:
    - stat_valid=1, stat_runt=0.
    - stat_calc=crc, the value before folding in the CRC byte.
    - stat_ok=(crc==in_data).
    - stat_len=len.
  - No transfer: all state holds; the hold byte is never lost or duplicated.
- Status fields are registered and stay stable until the next stat_valid pulse. stat_valid is high for exactly one cycle per frame.
- Back-to-back frames: a new frame may be accepted in the cycle right after the CRC byte, while stat_valid for the previous frame is high. There are no bubbles.
- Throughput: 1 byte/cycle when out_ready=1. Latency from payload byte accept to its output is one transfer, i.e. until the next input byte.
- stat_len saturation: stat_len holds at all-ones; CRC checking continues unaffected.
- Reset (async, any time, including mid-frame):
  - state=IDLE; hold_data, crc and len are cleared (crc=CRC_INIT).
  - stat_valid=0, stat_ok=0, stat_runt=0, stat_len=0, stat_calc=0.
  - out_valid=0, out_last=0; in_ready=0 while rst is high.
  - A partial frame is discarded with no status pulse.

Test Plan:
- Payload 0x31..0x39 ("123456789") then CRC 0xF4 with in_last, out_ready=1 -> 9 bytes out, out_last on 0x39; stat_valid 1 cycle later with ok=1, calc=0xF4, len=9, runt=0.
- Same payload with CRC byte 0xF5 -> identical payload out; stat ok=0, calc=0xF4, len=9.
- Payload 0x01 then CRC 0x07 -> single out byte 0x01 with out_last=1; stat ok=1, len=1, calc=0x07. Repeat with 0x80/0x89 and 0x00/0x00.
- Runt: single byte 0x5A with in_last -> no out_valid; stat runt=1, ok=0, len=0.
- Backpressure: drop out_ready for 3 cycles mid-frame -> in_ready=0 for those cycles, no byte lost or duplicated, final status ok=1; then two back-to-back frames with no idle cycle -> two correct stat pulses.
- Assert rst after 4 bytes of a frame -> no status pulse, outputs at reset values; the next clean frame passes with len counted from 1.
